traffic_light_monitor: RTL

- Passive checker on the light outputs of the intersection controller. It sits at the receiving end of the main_road/side_road light buses and tracks the same road phases from those buses.
- Flags illegal encodings, conflicting greens, out-of-order phases, wrong phase durations and stuck phases.
- Reports the length of the most recent main-road phase and counts completed main-road cycles.
- Used in simulation and as an on-chip safety monitor; it drives no lights.

---
 rtl/traffic_light_monitor.sv | 123 ++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// Passive safety checker for the intersection light buses: tracks main-road
// phases, flags illegal encodings/conflicts/sequences/timing/stuck phases.
module traffic_light_monitor #(
    parameter int CW         = 8,
    parameter int MIN_GREEN  = 11,
    parameter int MIN_YELLOW = 3,
    parameter int MAX_YELLOW = 3,
    parameter int MIN_RED    = 11,
    parameter int MAX_PHASE  = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2:0]    main_road,
    input  logic [2:0]    side_road,
    input  logic          clr_err,
    output logic          err_encoding,
    output logic          err_conflict,
    output logic          err_sequence,
    output logic          err_timing,
    output logic          err_stuck,
    output logic          err_any,
    output logic [CW-1:0] last_len,
    output logic [15:0]   cycle_count
);
    localparam logic [2:0]    RED = 3'b100;
    localparam logic [2:0]    YEL = 3'b010;
    localparam logic [2:0]    GRN = 3'b001;
    localparam logic [CW-1:0] L_MIN_G  = CW'(MIN_GREEN);
    localparam logic [CW-1:0] L_MIN_Y  = CW'(MIN_YELLOW);
    localparam logic [CW-1:0] L_MAX_Y  = CW'(MAX_YELLOW);
    localparam logic [CW-1:0] L_MIN_R  = CW'(MIN_RED);
    localparam logic [CW-1:0] L_MAXPH  = CW'(MAX_PHASE);

    logic [2:0]    r_mon_main;
    logic [CW-1:0] r_dwell;
    logic          r_prev_valid;
    logic          r_first_phase;
    logic          r_err_enc, r_err_conf, r_err_seq, r_err_tim, r_err_stk, r_err_any;
    logic [CW-1:0] r_last_len;
    logic [15:0]   r_cycle_count;

    logic          w_change, w_hold, w_legal, w_bad_len;
    logic [CW-1:0] w_dwell_inc;
    logic          w_v_enc, w_v_conf, w_v_seq, w_v_tim, w_v_stk;
    logic          w_enc_n, w_conf_n, w_seq_n, w_tim_n, w_stk_n;

    function automatic logic is_onehot(input logic [2:0] v);
        return (v == RED) || (v == YEL) || (v == GRN);
    endfunction

    always_comb begin
        w_change    = r_prev_valid && (main_road != r_mon_main);
        w_hold      = r_prev_valid && (main_road == r_mon_main);
        w_legal     = (r_mon_main == GRN && main_road == YEL) ||
                      (r_mon_main == YEL && main_road == RED) ||
                      (r_mon_main == RED && main_road == GRN);
        w_bad_len   = (r_mon_main == GRN && r_dwell < L_MIN_G) ||
                      (r_mon_main == YEL && (r_dwell < L_MIN_Y || r_dwell > L_MAX_Y)) ||
                      (r_mon_main == RED && r_dwell < L_MIN_R);
        w_dwell_inc = (r_dwell >= L_MAXPH) ? L_MAXPH : r_dwell + CW'(1);

        w_v_enc  = !is_onehot(main_road) || !is_onehot(side_road);
        w_v_conf = !main_road[2] && !side_road[2];
        w_v_seq  = w_change && !w_legal;
        // The phase in progress at reset release is partial, so its length is meaningless.
        w_v_tim  = w_change && !r_first_phase && w_bad_len;
        w_v_stk  = w_hold && (w_dwell_inc == L_MAXPH);

        // A new violation on the clearing edge wins over the clear.
        w_enc_n  = (r_err_enc  & ~clr_err) | w_v_enc;
        w_conf_n = (r_err_conf & ~clr_err) | w_v_conf;
        w_seq_n  = (r_err_seq  & ~clr_err) | w_v_seq;
        w_tim_n  = (r_err_tim  & ~clr_err) | w_v_tim;
        w_stk_n  = (r_err_stk  & ~clr_err) | w_v_stk;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mon_main    <= 3'b000;
            r_dwell       <= '0;
            r_prev_valid  <= 1'b0;
            r_first_phase <= 1'b1;
            r_err_enc     <= 1'b0;
            r_err_conf    <= 1'b0;
            r_err_seq     <= 1'b0;
            r_err_tim     <= 1'b0;
            r_err_stk     <= 1'b0;
            r_err_any     <= 1'b0;
            r_last_len    <= '0;
            r_cycle_count <= '0;
        end else begin
            r_err_enc  <= w_enc_n;
            r_err_conf <= w_conf_n;
            r_err_seq  <= w_seq_n;
            r_err_tim  <= w_tim_n;
            r_err_stk  <= w_stk_n;
            r_err_any  <= w_enc_n | w_conf_n | w_seq_n | w_tim_n | w_stk_n;
            if (!r_prev_valid) begin
                r_mon_main   <= main_road;
                r_dwell      <= CW'(1);
                r_prev_valid <= 1'b1;
            end else if (w_change) begin
                r_last_len    <= r_dwell;
                r_dwell       <= CW'(1);
                r_mon_main    <= main_road;
                r_first_phase <= 1'b0;
                if (r_mon_main == RED && main_road == GRN)
                    r_cycle_count <= r_cycle_count + 16'd1;
            end else begin
                r_dwell <= w_dwell_inc;
            end
        end
    end

    assign err_encoding = r_err_enc;
    assign err_conflict = r_err_conf;
    assign err_sequence = r_err_seq;
    assign err_timing   = r_err_tim;
    assign err_stuck    = r_err_stk;
    assign err_any      = r_err_any;
    assign last_len     = r_last_len;
    assign cycle_count  = r_cycle_count;
endmodule
